// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI slave blocks (shift-in receive path and the
// matching MISO shift-out register).
//
// Contents:
//   SPI_MODE0           {CPOL, CPHA} encoding of SPI mode 0
//   DEFAULT_DATA_WIDTH  default word width for the SPI datapath
//   cnt_width()         width of a counter that must hold 0..data_width
// -----------------------------------------------------------------------------
package spi_pkg;

    // {CPOL, CPHA}. Mode 0 idles sclk low and samples on the rising edge.
    localparam logic [1:0] SPI_MODE0 = 2'b00;

    localparam int DEFAULT_DATA_WIDTH = 8;

    // A bit counter has to represent every value from 0 up to the full word
    // length, so it needs one more code than there are bits in the word.
    function automatic int cnt_width(input int data_width);
        return $clog2(data_width + 1);
    endfunction

endpackage

// File: rtl/shiftin_rx_if.sv
// -----------------------------------------------------------------------------
// shiftin_rx_if
// Bundles the SPI pins and the consumer-side handshake/status of shiftin_rx.
//
// Signals:
//   sclk, cs_n, mosi   SPI pins (asynchronous to the system clock)
//   rx_data            last completed word
//   rx_valid           rx_data holds an unconsumed word
//   rx_ready           consumer accepts rx_data when rx_valid && rx_ready
//   clr_status         one-cycle pulse clearing overrun and frame_err
//   overrun            sticky: a completed word was dropped
//   frame_err          sticky: chip select released mid-word
//   busy               synchronised cs_n is low
//   bit_count          bits received so far in the current word
//
// Modports:
//   slave   the receiver's view (shiftin_rx)
//   master  the view of whatever drives the pins and consumes the words
// -----------------------------------------------------------------------------
interface shiftin_rx_if
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

    localparam int CNT_W = cnt_width(DATA_WIDTH);

    logic                  sclk;
    logic                  cs_n;
    logic                  mosi;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  clr_status;
    logic                  overrun;
    logic                  frame_err;
    logic                  busy;
    logic [CNT_W-1:0]      bit_count;

    modport slave (
        input  sclk,
        input  cs_n,
        input  mosi,
        input  rx_ready,
        input  clr_status,
        output rx_data,
        output rx_valid,
        output overrun,
        output frame_err,
        output busy,
        output bit_count
    );

    modport master (
        output sclk,
        output cs_n,
        output mosi,
        output rx_ready,
        output clr_status,
        input  rx_data,
        input  rx_valid,
        input  overrun,
        input  frame_err,
        input  busy,
        input  bit_count
    );

endinterface

// File: rtl/sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
// Multi-flop synchroniser for one asynchronous input, followed by a
// previous-value flop that turns level changes into one-cycle strobes.
//
// Parameters:
//   STAGES     synchroniser depth (2 or more)
//   RESET_VAL  value every flop takes in reset, i.e. the pin's idle level
//
// Ports:
//   clk    system clock
//   rst    asynchronous active-high reset
//   din    asynchronous input
//   level  synchronised level
//   rise   one-cycle strobe: level went 0 -> 1
//   fall   one-cycle strobe: level went 1 -> 0
// -----------------------------------------------------------------------------
module sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    // Resetting to the idle level keeps the strobes quiet coming out of reset,
    // so a pin already sitting at its idle value never fakes an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/shiftin_rx.sv
// -----------------------------------------------------------------------------
// shiftin_rx
// SPI slave receive path. Synchronises sclk, cs_n and mosi into the system
// clock domain, samples mosi on each rising sclk while selected, assembles
// DATA_WIDTH-bit words and hands them to the command decoder over a
// valid/ready handshake. Dropped words and aborted words raise sticky flags.
//
// Parameters:
//   DATA_WIDTH   bits per received word (2 or more)
//   SYNC_STAGES  synchroniser depth for sclk, cs_n and mosi (2 or more)
//   MSB_FIRST    1: first received bit lands in rx_data[DATA_WIDTH-1]
//                0: first received bit lands in rx_data[0]
//
// Ports:
//   clk   system clock, at least 4x the sclk rate
//   rst   asynchronous active-high reset
//   bus   shiftin_rx_if.slave: SPI pins, rx_data/rx_valid/rx_ready,
//         clr_status, overrun, frame_err, busy, bit_count
// -----------------------------------------------------------------------------
module shiftin_rx
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    shiftin_rx_if.slave  bus
);

    localparam int               CNT_W    = cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Synchronised pins and their edge strobes
    logic sclk_level;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_level;
    logic cs_rise;
    logic cs_fall;
    logic mosi_level;
    logic mosi_rise_unused;
    logic mosi_fall_unused;

    // Registered state
    logic [DATA_WIDTH-1:0] shifter;
    logic [CNT_W-1:0]      bit_count_q;
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic                  rx_valid_q;
    logic                  overrun_q;
    logic                  frame_err_q;
    logic                  busy_q;

    // Next-state helpers
    logic                  sample_edge;
    logic [DATA_WIDTH-1:0] shift_next;
    logic                  take_bit;
    logic                  word_done;
    logic                  accept;
    logic                  drop_word;
    logic                  abort_word;

    // All three pins share the same synchroniser depth, so a mosi value set up
    // before an sclk edge reaches the sample point together with that edge.
    sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sync_sclk (
        .clk   (clk),
        .rst   (rst),
        .din   (bus.sclk),
        .level (sclk_level),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync_cs (
        .clk   (clk),
        .rst   (rst),
        .din   (bus.cs_n),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sync_mosi (
        .clk   (clk),
        .rst   (rst),
        .din   (bus.mosi),
        .level (mosi_level),
        .rise  (mosi_rise_unused),
        .fall  (mosi_fall_unused)
    );

    // Mode 0 samples on the leading edge with sclk idling low, which is the
    // rising edge. The selection is written out so the idle polarity and phase
    // live in one place in the package. The synchronised sclk level itself is
    // only needed to produce the strobes.
    assign sample_edge = (SPI_MODE0[1] ^ SPI_MODE0[0]) ? sclk_fall : sclk_rise;

    // Decide what this cycle does before touching any state. A chip-select
    // edge always takes priority over a sample so a deselect that coincides
    // with an sclk edge discards that edge rather than counting it. A word
    // that completes while the previous one is still pending and not being
    // accepted this very cycle is dropped; if the consumer is accepting in the
    // same cycle the slot frees up and the new word simply replaces it.
    always_comb begin
        shift_next = MSB_FIRST ? {shifter[DATA_WIDTH-2:0], mosi_level}
                               : {mosi_level, shifter[DATA_WIDTH-1:1]};
        take_bit   = sample_edge && !cs_level && !cs_rise && !cs_fall;
        word_done  = take_bit && (bit_count_q == LAST_BIT);
        accept     = rx_valid_q && bus.rx_ready;
        drop_word  = word_done && rx_valid_q && !bus.rx_ready;
        abort_word = cs_rise && (bit_count_q != '0);
    end

    // Shifter, bit counter, output word and sticky flags. The counter wraps to
    // zero on the word's last bit so the next word can start on the very next
    // sclk edge. Sticky flags give a new set event priority over clr_status so
    // an error arriving in the clearing cycle is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shifter     <= '0;
            bit_count_q <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            busy_q <= ~cs_level;

            if (cs_rise || cs_fall) begin
                shifter     <= '0;
                bit_count_q <= '0;
            end else if (take_bit) begin
                shifter     <= shift_next;
                bit_count_q <= word_done ? '0 : bit_count_q + CNT_ONE;
            end

            if (word_done && !drop_word) begin
                rx_data_q  <= shift_next;
                rx_valid_q <= 1'b1;
            end else if (accept) begin
                rx_valid_q <= 1'b0;
            end

            overrun_q   <= drop_word  | (overrun_q   & ~bus.clr_status);
            frame_err_q <= abort_word | (frame_err_q & ~bus.clr_status);
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.overrun   = overrun_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = busy_q;
    assign bus.bit_count = bit_count_q;

endmodule

// File: tb/tb_shiftin_rx.sv
// -----------------------------------------------------------------------------
// tb_shiftin_rx
// Directed testbench for shiftin_rx. Two receivers share the same SPI pins and
// consumer controls: one assembles MSB-first, the other LSB-first. sclk runs
// at clk/8; inputs change and outputs are sampled on the falling clk edge.
// -----------------------------------------------------------------------------
module tb_shiftin_rx;
    import spi_pkg::*;

    localparam int DW    = 8;
    localparam int CNT_W = cnt_width(DW);

    logic clk = 1'b0;
    logic rst;
    logic sclk;
    logic cs_n;
    logic mosi;
    logic rx_ready;
    logic clr_status;

    int         checks       = 0;
    int         failures     = 0;
    int         valid_cycles = 0;
    logic [7:0] seen_data    = 8'h00;

    always #5 clk = ~clk;

    shiftin_rx_if #(.DATA_WIDTH(DW)) bus_a ();
    shiftin_rx_if #(.DATA_WIDTH(DW)) bus_b ();

    assign bus_a.sclk       = sclk;
    assign bus_a.cs_n       = cs_n;
    assign bus_a.mosi       = mosi;
    assign bus_a.rx_ready   = rx_ready;
    assign bus_a.clr_status = clr_status;
    assign bus_b.sclk       = sclk;
    assign bus_b.cs_n       = cs_n;
    assign bus_b.mosi       = mosi;
    assign bus_b.rx_ready   = rx_ready;
    assign bus_b.clr_status = clr_status;

    shiftin_rx #(
        .DATA_WIDTH  (DW),
        .SYNC_STAGES (2),
        .MSB_FIRST   (1'b1)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    shiftin_rx #(
        .DATA_WIDTH  (DW),
        .SYNC_STAGES (2),
        .MSB_FIRST   (1'b0)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // Records how many cycles rx_valid was seen high and the word it carried
    always @(negedge clk) begin
        if (bus_a.rx_valid === 1'b1) begin
            valid_cycles = valid_cycles + 1;
            seen_data    = bus_a.rx_data;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SPI bit: data set up while sclk is low, then a full sclk period
    task automatic send_bit(input logic b);
        mosi = b;
        wait_cycles(4);
        sclk = 1'b1;
        wait_cycles(4);
        sclk = 1'b0;
    endtask

    // Bits go out on the wire most significant first
    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic select_slave();
        cs_n = 1'b0;
        wait_cycles(4);
    endtask

    task automatic deselect_slave();
        cs_n = 1'b1;
        wait_cycles(6);
    endtask

    task automatic pulse_ready();
        rx_ready = 1'b1;
        wait_cycles(1);
        rx_ready = 1'b0;
        wait_cycles(1);
    endtask

    task automatic pulse_clr();
        clr_status = 1'b1;
        wait_cycles(1);
        clr_status = 1'b0;
        wait_cycles(1);
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        sclk       = 1'b0;
        cs_n       = 1'b1;
        mosi       = 1'b0;
        rx_ready   = 1'b0;
        clr_status = 1'b0;
        wait_cycles(3);
        checks++; if (bus_a.rx_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_rx_data got=%h exp=00", bus_a.rx_data); end
        checks++; if (bus_a.rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rx_valid got=%b exp=0", bus_a.rx_valid); end
        checks++; if (bus_a.overrun !== 1'b0) begin failures++; $display("[TB] FAIL reset_overrun got=%b exp=0", bus_a.overrun); end
        checks++; if (bus_a.frame_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_err got=%b exp=0", bus_a.frame_err); end
        checks++; if (bus_a.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", bus_a.busy); end
        checks++; if (bus_a.bit_count !== CNT_W'(0)) begin failures++; $display("[TB] FAIL reset_bit_count got=%0d exp=0", bus_a.bit_count); end
        rst = 1'b0;
        wait_cycles(4);
        checks++; if (bus_a.busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_busy got=%b exp=0", bus_a.busy); end
    endtask

    task automatic test_single_word();
        rx_ready     = 1'b1;
        valid_cycles = 0;
        select_slave();
        send_byte(8'hA5);
        wait_cycles(6);
        checks++; if (valid_cycles !== 1) begin failures++; $display("[TB] FAIL single_valid_pulse got=%0d cycles exp=1", valid_cycles); end
        checks++; if (seen_data !== 8'hA5) begin failures++; $display("[TB] FAIL single_rx_data got=%h exp=a5", seen_data); end
        checks++; if (bus_a.rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_consumed got=%b exp=0", bus_a.rx_valid); end
        checks++; if (bus_a.overrun !== 1'b0) begin failures++; $display("[TB] FAIL single_overrun got=%b exp=0", bus_a.overrun); end
        checks++; if (bus_a.busy !== 1'b1) begin failures++; $display("[TB] FAIL single_busy got=%b exp=1", bus_a.busy); end
        checks++; if (bus_a.bit_count !== CNT_W'(0)) begin failures++; $display("[TB] FAIL single_bit_count got=%0d exp=0", bus_a.bit_count); end
        deselect_slave();
        rx_ready = 1'b0;
        checks++; if (bus_a.frame_err !== 1'b0) begin failures++; $display("[TB] FAIL single_frame_err got=%b exp=0", bus_a.frame_err); end
        checks++; if (bus_a.busy !== 1'b0) begin failures++; $display("[TB] FAIL single_busy_after got=%b exp=0", bus_a.busy); end
    endtask

    task automatic test_back_to_back();
        rx_ready = 1'b0;
        select_slave();
        send_byte(8'h3C);
        checks++; if (bus_a.rx_data !== 8'h3C) begin failures++; $display("[TB] FAIL b2b_first_data got=%h exp=3c", bus_a.rx_data); end
        send_byte(8'hC3);
        wait_cycles(2);
        checks++; if (bus_a.rx_data !== 8'h3C) begin failures++; $display("[TB] FAIL b2b_kept_data got=%h exp=3c", bus_a.rx_data); end
        checks++; if (bus_a.rx_valid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_valid got=%b exp=1", bus_a.rx_valid); end
        checks++; if (bus_a.overrun !== 1'b1) begin failures++; $display("[TB] FAIL b2b_overrun got=%b exp=1", bus_a.overrun); end
        pulse_clr();
        checks++; if (bus_a.overrun !== 1'b0) begin failures++; $display("[TB] FAIL b2b_overrun_clr got=%b exp=0", bus_a.overrun); end
        deselect_slave();
        checks++; if (bus_a.frame_err !== 1'b0) begin failures++; $display("[TB] FAIL b2b_frame_err got=%b exp=0", bus_a.frame_err); end
        pulse_ready();
        checks++; if (bus_a.rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_consume got=%b exp=0", bus_a.rx_valid); end
        checks++; if (bus_a.rx_data !== 8'h3C) begin failures++; $display("[TB] FAIL b2b_data_hold got=%h exp=3c", bus_a.rx_data); end
    endtask

    task automatic test_same_cycle();
        logic [7:0] second;
        second   = 8'h81;
        rx_ready = 1'b0;
        select_slave();
        send_byte(8'h7E);
        checks++; if (bus_a.rx_data !== 8'h7E || bus_a.rx_valid !== 1'b1) begin failures++; $display("[TB] FAIL same_first got=%h/%b exp=7e/1", bus_a.rx_data, bus_a.rx_valid); end
        for (int i = 7; i >= 1; i--) send_bit(second[i]);
        // Last bit: the sample happens on the third clk rise after sclk rises
        mosi = second[0];
        wait_cycles(4);
        sclk = 1'b1;
        wait_cycles(2);
        rx_ready = 1'b1;
        wait_cycles(1);
        rx_ready = 1'b0;
        checks++; if (bus_a.rx_data !== 8'h81) begin failures++; $display("[TB] FAIL same_rx_data got=%h exp=81", bus_a.rx_data); end
        checks++; if (bus_a.rx_valid !== 1'b1) begin failures++; $display("[TB] FAIL same_rx_valid got=%b exp=1", bus_a.rx_valid); end
        checks++; if (bus_a.overrun !== 1'b0) begin failures++; $display("[TB] FAIL same_overrun got=%b exp=0", bus_a.overrun); end
        wait_cycles(1);
        sclk = 1'b0;
        wait_cycles(4);
        pulse_ready();
        deselect_slave();
        pulse_clr();
    endtask

    task automatic test_aborted_frame();
        select_slave();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        checks++; if (bus_a.bit_count !== CNT_W'(5)) begin failures++; $display("[TB] FAIL abort_partial_count got=%0d exp=5", bus_a.bit_count); end
        deselect_slave();
        checks++; if (bus_a.frame_err !== 1'b1) begin failures++; $display("[TB] FAIL abort_frame_err got=%b exp=1", bus_a.frame_err); end
        checks++; if (bus_a.bit_count !== CNT_W'(0)) begin failures++; $display("[TB] FAIL abort_bit_count got=%0d exp=0", bus_a.bit_count); end
        checks++; if (bus_a.rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL abort_rx_valid got=%b exp=0", bus_a.rx_valid); end
        pulse_clr();
        checks++; if (bus_a.frame_err !== 1'b0) begin failures++; $display("[TB] FAIL abort_clr got=%b exp=0", bus_a.frame_err); end
        select_slave();
        send_byte(8'h0F);
        deselect_slave();
        checks++; if (bus_a.rx_data !== 8'h0F || bus_a.rx_valid !== 1'b1) begin failures++; $display("[TB] FAIL abort_next_word got=%h/%b exp=0f/1", bus_a.rx_data, bus_a.rx_valid); end
        checks++; if (bus_a.frame_err !== 1'b0) begin failures++; $display("[TB] FAIL abort_next_frame_err got=%b exp=0", bus_a.frame_err); end
        pulse_ready();
    endtask

    task automatic test_idle_clocks();
        cs_n = 1'b1;
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        wait_cycles(4);
        checks++; if (bus_a.bit_count !== CNT_W'(0)) begin failures++; $display("[TB] FAIL idle_bit_count got=%0d exp=0", bus_a.bit_count); end
        checks++; if (bus_a.rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL idle_rx_valid got=%b exp=0", bus_a.rx_valid); end
        checks++; if (bus_a.frame_err !== 1'b0 || bus_a.overrun !== 1'b0) begin failures++; $display("[TB] FAIL idle_flags got=%b%b exp=00", bus_a.frame_err, bus_a.overrun); end
    endtask

    task automatic test_reset_midword();
        select_slave();
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        checks++; if (bus_a.bit_count !== CNT_W'(3) || bus_a.busy !== 1'b1) begin failures++; $display("[TB] FAIL midrst_before got=%0d/%b exp=3/1", bus_a.bit_count, bus_a.busy); end
        rst  = 1'b1;
        cs_n = 1'b1;
        wait_cycles(2);
        checks++; if (bus_a.rx_data !== 8'h00) begin failures++; $display("[TB] FAIL midrst_rx_data got=%h exp=00", bus_a.rx_data); end
        checks++; if (bus_a.bit_count !== CNT_W'(0)) begin failures++; $display("[TB] FAIL midrst_bit_count got=%0d exp=0", bus_a.bit_count); end
        checks++; if (bus_a.busy !== 1'b0 || bus_a.rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy_valid got=%b/%b exp=0/0", bus_a.busy, bus_a.rx_valid); end
        rst = 1'b0;
        wait_cycles(4);
        checks++; if (bus_a.frame_err !== 1'b0 || bus_a.overrun !== 1'b0) begin failures++; $display("[TB] FAIL midrst_flags got=%b%b exp=00", bus_a.frame_err, bus_a.overrun); end
        select_slave();
        send_byte(8'h55);
        deselect_slave();
        checks++; if (bus_a.rx_data !== 8'h55 || bus_a.rx_valid !== 1'b1) begin failures++; $display("[TB] FAIL midrst_next_word got=%h/%b exp=55/1", bus_a.rx_data, bus_a.rx_valid); end
        checks++; if (bus_a.frame_err !== 1'b0) begin failures++; $display("[TB] FAIL midrst_frame_err got=%b exp=0", bus_a.frame_err); end
    endtask

    task automatic test_lsb_first();
        rst = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(4);
        select_slave();
        send_byte(8'h80);
        deselect_slave();
        checks++; if (bus_b.rx_data !== 8'h01) begin failures++; $display("[TB] FAIL lsb_rx_data got=%h exp=01", bus_b.rx_data); end
        checks++; if (bus_b.rx_valid !== 1'b1) begin failures++; $display("[TB] FAIL lsb_rx_valid got=%b exp=1", bus_b.rx_valid); end
        checks++; if (bus_a.rx_data !== 8'h80) begin failures++; $display("[TB] FAIL lsb_msb_ref got=%h exp=80", bus_a.rx_data); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_same_cycle();
        test_aborted_frame();
        test_idle_clocks();
        test_reset_midword();
        test_lsb_first();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shiftin_rx.md
Name: shiftin_rx

Overview:
- SPI-slave receive path: deserialises MOSI into DATA_WIDTH-bit words. Counterpart of the MISO shift-out register.
- Runs entirely on the system clock. Synchronises sclk, cs_n and mosi, then detects sclk edges.
- Presents completed words on a valid/ready handshake to the command decoder, with sticky overrun and framing-error flags.

Parameters:
- DATA_WIDTH, 8, bits per received word.
- SYNC_STAGES, 2, synchroniser depth for sclk, cs_n and mosi (minimum 2).
- MSB_FIRST, 1, 1 = first received bit lands in rx_data[DATA_WIDTH-1]; 0 = first bit lands in rx_data[0].

Ports:
- clk  input  1  system clock; all state on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- sclk  input  1  SPI serial clock (async to clk), mode 0: sample on rising edge.
- cs_n  input  1  SPI chip select, active-low (async).
- mosi  input  1  SPI serial data in (async).
- rx_data  output  DATA_WIDTH  last completed word.
- rx_valid  output  1  rx_data holds an unconsumed word.
- rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready.
- clr_status  input  1  one-cycle pulse; clears overrun and frame_err.
- overrun  output  1  sticky: a completed word was dropped.
- frame_err  output  1  sticky: cs_n deasserted mid-word.
- busy  output  1  synchronised cs_n is low.
- bit_count  output  $clog2(DATA_WIDTH+1)  bits received in the current word.

Behaviour:
- Reset state:
  - Synchroniser flops: sclk=0, cs_n=1, mosi=0.
  - shifter=0, bit_count=0, rx_data=0.
  - rx_valid, overrun, frame_err, busy all 0.
- Synchronisers and edge detection:
  - Each async input passes through SYNC_STAGES flops.
  - A previous-value flop on synced sclk and on synced cs_n gives one-cycle strobes: sclk_rise, cs_fall, cs_rise.
- Clock ratio: clk must be at least 4x sclk. Under that rule no edge is ever missed, and no check for missed edges is required.
- Sample point: on a clk cycle with sclk_rise and synced cs_n=0, the synced mosi is shifted in.
  - Shift direction is set by MSB_FIRST.
  - bit_count increments.
- Pin-to-shift latency: SYNC_STAGES+1 clk cycles after the sclk pin rises.
- Word completion: the cycle in which the DATA_WIDTH-th bit is sampled:
  - The assembled word, including that bit, is written to rx_data.
  - rx_valid = 1 from the next cycle.
  - bit_count returns to 0.
  - The next word starts with no gap.
- Handshake:
  - rx_data and rx_valid hold until a cycle with rx_valid && rx_ready; rx_valid then clears.
  - rx_ready while rx_valid = 0 has no effect.
- Overrun: a word completes while rx_valid=1 and rx_ready=0 in that cycle.
  - The new word is discarded; rx_data is unchanged.
  - overrun is set.
- Simultaneous accept and complete: the new word loads, rx_valid stays 1, no overrun.
- cs_fall: bit_count and shifter clear; busy = 1.
- cs_rise:
  - busy = 0.
  - If bit_count != 0: the partial word is discarded, frame_err is set, bit_count clears.
  - rx_data and rx_valid are unaffected.
- sclk_rise in the same cycle as cs_rise: the deselect wins and the edge is ignored.
- sclk_rise while synced cs_n=1: ignored.
- Falling sclk edges: no effect.
- clr_status:
  - Clears overrun and frame_err.
  - If a set condition occurs in the same cycle, the set wins.
- rst asserted mid-word: all state returns to reset values immediately. The partial word is lost and no flag is raised.

Decomposition:
- Shared spi_pkg holds:
  - SPI_MODE0 constant.
  - Default DATA_WIDTH.
  - Function to compute the bit_count width.
- One sub-module, sync_edge: an SYNC_STAGES-deep synchroniser plus rise/fall strobe outputs, instantiated three times (mosi uses the level output only).
- The shifter, counter, handshake and flags stay in shiftin_rx.

Test Plan:
- Single word: cs_n low, send 0xA5 MSB-first at clk/8, rx_ready=1 → rx_valid pulses one cycle with rx_data=0xA5; overrun=0; frame_err=0.
- Back-to-back: 0x3C then 0xC3 in one frame, rx_ready held 0 until both are sent → rx_data=0x3C, overrun=1. After clr_status, overrun=0.
- Same-cycle accept and complete: rx_ready pulsed exactly in the cycle the second word (0x81) completes → rx_data=0x81, rx_valid stays 1, overrun=0.
- Aborted frame: 5 bits then cs_n high → frame_err=1, bit_count=0, rx_valid unchanged. The next full word 0x0F is received correctly.
- Idle clocks and reset: sclk toggling with cs_n high → bit_count stays 0, rx_valid stays 0. rst pulsed after 3 bits of a word → every output returns to its reset value and the next 0x55 is received correctly.
- MSB_FIRST=0: send bits 1,0,0,0,0,0,0,0 → rx_data=0x01.
